// File: rtl/musb_pc_sequencer_if.sv
// Fetch-side bus of the MUSB IF stage: redirect inputs, memory handshake and PC status outputs.
interface musb_pc_sequencer_if #(
  parameter int unsigned PC_WIDTH = 32
) ();
  logic                if_stall;
  logic                if_ready;
  logic                ex_redirect;
  logic [PC_WIDTH-1:0] ex_redirect_pc;
  logic                exc_valid;
  logic [PC_WIDTH-1:0] exc_vector;
  logic [PC_WIDTH-1:0] if_pc;
  logic                if_req;
  logic                if_flush;
  logic                if_misaligned;
  logic                if_pending;

  modport master (
    input  if_stall, if_ready, ex_redirect, ex_redirect_pc, exc_valid, exc_vector,
    output if_pc, if_req, if_flush, if_misaligned, if_pending
  );

  modport slave (
    output if_stall, if_ready, ex_redirect, ex_redirect_pc, exc_valid, exc_vector,
    input  if_pc, if_req, if_flush, if_misaligned, if_pending
  );
endinterface

// File: rtl/musb_pc_sequencer.sv
// MUSB fetch-address sequencer: holds the PC, steps it sequentially and applies
// exception/branch redirects, buffering one redirect while fetch cannot advance.
module musb_pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0010,
  parameter int unsigned INSTR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  musb_pc_sequencer_if.master   bus
);

  localparam logic [PC_WIDTH-1:0] ResetPc   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] Incr      = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] AlignMask = Incr - PC_WIDTH'(1);

  typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                pend_exc_q, pend_exc_d;
  logic                flush_q, flush_d;
  logic                misal_q, misal_d;
  logic                req;
  logic                pend_valid;
  logic                advance;

  assign req        = (state_q != StBoot);
  assign pend_valid = (state_q == StPend);
  assign advance    = req & bus.if_ready & ~bus.if_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= ResetPc;
      pend_pc_q  <= '0;
      pend_exc_q <= 1'b0;
      flush_q    <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_exc_q <= pend_exc_d;
      flush_q    <= flush_d;
      misal_q    <= misal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_exc_d = pend_exc_q;
    flush_d    = 1'b0;
    if (advance) begin
      // Any applied redirect also discards whatever was buffered.
      state_d    = StRun;
      pend_exc_d = 1'b0;
      if (bus.exc_valid) begin
        pc_d    = bus.exc_vector;
        flush_d = 1'b1;
      end else if (bus.ex_redirect) begin
        pc_d    = bus.ex_redirect_pc;
        flush_d = 1'b1;
      end else if (pend_valid) begin
        pc_d    = pend_pc_q;
        flush_d = 1'b1;
      end else begin
        pc_d = pc_q + Incr;
      end
    end else begin
      if (state_q == StBoot) begin
        state_d = StRun;
      end
      // Exceptions always win the buffer; a branch never displaces a held exception.
      if (bus.exc_valid) begin
        pend_pc_d  = bus.exc_vector;
        pend_exc_d = 1'b1;
        state_d    = StPend;
      end else if (bus.ex_redirect && !(pend_valid && pend_exc_q)) begin
        pend_pc_d  = bus.ex_redirect_pc;
        pend_exc_d = 1'b0;
        state_d    = StPend;
      end
    end
    misal_d = |(pc_d & AlignMask);
  end

  always_comb begin
    bus.if_pc         = pc_q;
    bus.if_req        = req;
    bus.if_flush      = flush_q;
    bus.if_misaligned = misal_q;
    bus.if_pending    = pend_valid;
  end

endmodule

// File: doc/musb_pc_sequencer.md
Name: musb_pc_sequencer

Overview:
Parametrised fetch-address sequencer for the MUSB IF stage. It holds the PC, generates sequential fetch addresses, and arbitrates exception and branch/jump redirects. Redirects that arrive while fetch cannot advance are captured in a one-entry pending buffer instead of being lost. It drives the instruction memory/ICache request with a ready handshake and flags the flush and misalignment conditions for the downstream stages.

Parameters:
PC_WIDTH, 32, width of all address ports and registers.
RESET_VECTOR, 32'h0000_0010, PC value loaded on reset; truncated to PC_WIDTH.
INSTR_BYTES, 4, sequential increment in bytes; must be a power of two.

Ports:
clk  in  1  main clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
if_stall  in  1  pipeline stall from hazard/ID logic; freezes the PC.
if_ready  in  1  memory accepted the current request this cycle.
ex_redirect  in  1  branch/jump taken (single-cycle pulse).
ex_redirect_pc  in  PC_WIDTH  branch/jump target.
exc_valid  in  1  exception/interrupt entry (single-cycle pulse).
exc_vector  in  PC_WIDTH  exception handler address.
if_pc  out  PC_WIDTH  current fetch address.
if_req  out  1  fetch request to the instruction memory/ICache.
if_flush  out  1  high for one cycle when if_pc was loaded from a redirect or exception.
if_misaligned  out  1  if_pc is not INSTR_BYTES-aligned.
if_pending  out  1  a redirect is held in the pending buffer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - if_pc = RESET_VECTOR.
  - if_req = 0, if_flush = 0, if_misaligned = 0, if_pending = 0.
  - Pending buffer cleared; FSM enters BOOT.
- Reset asserted mid-operation overrides everything in the same instant, including an in-flight request or a held pending redirect.
- FSM states:
  - BOOT: if_req = 0 for exactly one cycle after rst_n rises, then go to RUN unconditionally.
  - RUN: if_req = 1.
  - PEND: if_req = 1 and a redirect is buffered.
- advance = if_req & if_ready & ~if_stall. if_pc only changes on a clock edge where advance = 1. This keeps the address stable while a request is outstanding, and during a stall.
- Next-PC priority on an advance edge, highest first:
  1. exc_valid: load exc_vector.
  2. ex_redirect: load ex_redirect_pc.
  3. pending buffer valid: load the buffered target.
  4. Otherwise: if_pc + INSTR_BYTES, modulo 2^PC_WIDTH (wraps from all-ones to 0; no carry out).
- Any load from options 1–3 clears the pending buffer, returns the FSM to RUN, and sets if_flush = 1 for the following cycle.
- Sequential advances set if_flush = 0.
- Event arriving with advance = 0 (or in BOOT):
  - The target is captured in the pending buffer; FSM goes to PEND; if_pending = 1 from the next cycle.
  - An exception overwrites a pending branch.
  - A branch never overwrites a pending exception; it is dropped.
  - Two events in the same cycle: only the exception is captured.
  - Pending captured during BOOT is applied on the first advance in RUN.
- Event arriving with advance = 1: applied directly and never buffered. Any older pending entry is discarded in that case.
- Latency: a redirect with advance = 1 appears on if_pc one cycle later. A buffered redirect appears one cycle after the first advance edge.
- if_misaligned is registered alongside if_pc: it equals (loaded value mod INSTR_BYTES) != 0. The PC is still loaded; exception generation is the responsibility of the downstream stages.
- The pending flag is set only on capture and cleared only on apply or reset.

Test Plan:
1. Reset release:
   - Stimulus: rst_n low then high; if_ready = 1, if_stall = 0.
   - Required: if_pc = 0x10 with if_req = 0 for one cycle.
   - Required: then 0x10, 0x14, 0x18 on successive cycles; if_flush = 0 throughout.
2. Stall and not-ready hold:
   - Stimulus: at pc = 0x20, if_stall = 1 for 3 cycles, then if_ready = 0 for 2 cycles.
   - Required: if_pc holds 0x20 for all 5 cycles, then advances to 0x24.
3. Direct redirect:
   - Stimulus: ex_redirect = 1, ex_redirect_pc = 0x400 while advancing.
   - Required: next cycle if_pc = 0x400 and if_flush = 1; the following cycle if_pc = 0x404 and if_flush = 0.
4. Buffered redirect and exception priority:
   - Stimulus: with if_stall = 1, ex_redirect to 0x400; next cycle exc_valid to 0x80; then a further branch to 0x500.
   - Required: if_pending = 1.
   - Required: on stall release, if_pc = 0x80 with if_flush = 1, and if_pending = 0.
5. Wrap and misalignment:
   - Stimulus: redirect to 0xFFFF_FFFC, advance.
   - Required: if_pc = 0x0000_0000.
   - Stimulus: redirect to 0x402.
   - Required: if_pc = 0x402, if_misaligned = 1.
6. Asynchronous reset mid-pending:
   - Stimulus: pull rst_n low between clock edges while if_pending = 1.
   - Required: immediately if_pc = 0x10, if_pending = 0, if_req = 0.
   - Required: after release, fetch resumes at 0x10 and the buffered target is never fetched.
